// File: rtl/muldiv_issue_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_issue_ctrl_pkg
// Description : Shared definitions for the EX-stage divider issue controller.
//               Contains the op codes, the controller state encoding, the
//               HI/LO split of the divider result and a small decode helper.
// Revision    : 1.0 - initial release
// ============================================================================
package muldiv_issue_ctrl_pkg;

  // EX-stage op codes seen by the controller
  localparam logic [2:0] OP_NONE = 3'd0;
  localparam logic [2:0] OP_DIV  = 3'd1;
  localparam logic [2:0] OP_DIVU = 3'd2;
  localparam logic [2:0] OP_MTHI = 3'd3;
  localparam logic [2:0] OP_MTLO = 3'd4;

  // Controller state encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Divider result layout: {remainder -> HI, quotient -> LO}
  localparam int HI_MSB = 63;
  localparam int HI_LSB = 32;
  localparam int LO_MSB = 31;
  localparam int LO_LSB = 0;

  // True for the two ops that need the iterative divider
  function automatic logic is_div_op(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage : muldiv_issue_ctrl_pkg
`default_nettype wire

// File: rtl/muldiv_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_issue_ctrl
// Description : Initiator side of the iterative divider Start/Annul/Ready
//               handshake in the EX stage. Issues DIV/DIVU, stalls IF..EX
//               until the divider answers, owns HI/LO, executes MTHI/MTLO,
//               annuls the divider on EX flush or watchdog expiry.
// Revision    : 1.0 - initial release
//
// Ports
//   clk, rst           : clock, synchronous active-high reset
//   op_valid/op        : EX instruction valid and op code
//   op_a, op_b         : rs (dividend / MTHI/MTLO source), rt (divisor)
//   ex_flush           : kill the current EX instruction
//   ex_stall           : freeze IF..EX
//   busy               : controller not idle
//   div_start          : divider Start, high for the whole operation
//   div_signed         : divider Signed (registered)
//   div_a, div_b       : registered dividend / divisor
//   div_annul          : one-cycle divider abort
//   div_result         : {remainder, quotient} from the divider
//   div_ready          : divider result valid, held while Start is high
//   hi, lo             : architectural HI/LO registers
//   timeout_err        : sticky watchdog flag
// ============================================================================
module muldiv_issue_ctrl
  import muldiv_issue_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        ex_flush,
  output logic        ex_stall,
  output logic        busy,
  output logic        div_start,
  output logic        div_signed,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  output logic        div_annul,
  input  logic [63:0] div_result,
  input  logic        div_ready,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        timeout_err
);

  localparam int              c_cnt_w   = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_lim = c_cnt_w'(TIMEOUT);

  logic [1:0]         r_state;
  logic [1:0]         w_next_state;
  logic [c_cnt_w-1:0] r_cnt;
  logic [63:0]        r_hold;
  logic [31:0]        r_hi;
  logic [31:0]        r_lo;
  logic [31:0]        r_div_a;
  logic [31:0]        r_div_b;
  logic               r_div_signed;
  logic               r_terr;

  logic w_idle_op;
  logic w_accept;
  logic w_active;
  logic w_wait_ready;
  logic w_flush_abort;
  logic w_timeout;
  logic w_capture;

  // A valid, unflushed instruction presented while idle
  assign w_idle_op     = (r_state == ST_IDLE) && op_valid && !ex_flush;
  // A zero divisor never reaches the divider; HI/LO are left alone
  assign w_accept      = w_idle_op && is_div_op(op) && (op_b != 32'd0);
  assign w_active      = (r_state == ST_ISSUE) || (r_state == ST_WAIT);
  // Ready is only trusted in WAIT: in ISSUE it may still be left over
  // from the previous operation
  assign w_wait_ready  = (r_state == ST_WAIT) && div_ready;
  assign w_flush_abort = w_active && ex_flush;
  assign w_timeout     = w_active && !ex_flush && !w_wait_ready && (r_cnt == c_cnt_lim);
  assign w_capture     = w_wait_ready && !ex_flush;

  assign ex_stall    = w_accept || w_active;
  assign busy        = (r_state != ST_IDLE);
  assign div_start   = w_active && !ex_flush && !w_timeout;
  assign div_annul   = w_flush_abort || w_timeout;
  assign div_signed  = r_div_signed;
  assign div_a       = r_div_a;
  assign div_b       = r_div_b;
  assign hi          = r_hi;
  assign lo          = r_lo;
  assign timeout_err = r_terr;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_next_state = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (w_flush_abort || w_timeout) w_next_state = ST_IDLE;
        else                            w_next_state = ST_WAIT;
      end
      ST_WAIT: begin
        if (w_flush_abort || w_timeout) w_next_state = ST_IDLE;
        else if (w_capture)             w_next_state = ST_DONE;
      end
      // DONE always returns to IDLE so the instruction is never re-issued
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_hold       <= '0;
      r_hi         <= '0;
      r_lo         <= '0;
      r_div_a      <= '0;
      r_div_b      <= '0;
      r_div_signed <= 1'b0;
      r_terr       <= 1'b0;
    end else begin
      r_state <= w_next_state;

      if (w_accept) begin
        r_div_a      <= op_a;
        r_div_b      <= op_b;
        r_div_signed <= (op == OP_DIV);
        r_cnt        <= '0;
      end else if (w_active) begin
        r_cnt <= r_cnt + c_cnt_w'(1);
      end

      if (w_capture) r_hold <= div_result;

      if (w_timeout) r_terr <= 1'b1;

      // HI/LO writers: MTHI/MTLO while idle, divider result in DONE
      if (w_idle_op && (op == OP_MTHI)) r_hi <= op_a;
      if (w_idle_op && (op == OP_MTLO)) r_lo <= op_a;
      if ((r_state == ST_DONE) && !ex_flush) begin
        r_hi <= r_hold[HI_MSB:HI_LSB];
        r_lo <= r_hold[LO_MSB:LO_LSB];
      end
    end
  end

endmodule : muldiv_issue_ctrl
`default_nettype wire

// File: tb/tb_muldiv_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_issue_ctrl
// Description : Self-checking bench for muldiv_issue_ctrl. A behavioural
//               divider answers the handshake with a programmable latency;
//               a reference model predicts HI/LO, stall length, Start/Annul
//               cycle counts and the watchdog flag for every instruction.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_issue_ctrl;
  import muldiv_issue_ctrl_pkg::*;

  localparam int TO = 15;

  logic        clk;
  logic        rst;
  logic        op_valid;
  logic [2:0]  op;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        ex_flush;
  logic        ex_stall;
  logic        busy;
  logic        div_start;
  logic        div_signed;
  logic [31:0] div_a;
  logic [31:0] div_b;
  logic        div_annul;
  logic [63:0] div_result;
  logic        div_ready;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        timeout_err;

  muldiv_issue_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op(op), .op_a(op_a), .op_b(op_b),
    .ex_flush(ex_flush), .ex_stall(ex_stall), .busy(busy), .div_start(div_start),
    .div_signed(div_signed), .div_a(div_a), .div_b(div_b), .div_annul(div_annul),
    .div_result(div_result), .div_ready(div_ready), .hi(hi), .lo(lo),
    .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // {remainder, quotient} as the architecture defines DIV/DIVU
  function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r;
    if (b == 32'd0) return 64'd0;
    if (sgn) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  // Behavioural divider: Ready rises dv_lat Start-high edges after Start,
  // and is held while Start stays high. With dv_sticky set, a finished
  // Ready lingers until the next Start is seen.
  int unsigned dv_lat = 0;
  bit          dv_sticky = 1'b0;
  int unsigned dv_cnt;

  always @(posedge clk) begin
    if (rst) begin
      dv_cnt     <= 0;
      div_ready  <= 1'b0;
      div_result <= '0;
    end else if (!div_start) begin
      dv_cnt <= 0;
      if (!dv_sticky) div_ready <= 1'b0;
    end else begin
      if (dv_cnt == 0) div_ready <= 1'b0;
      dv_cnt <= dv_cnt + 1;
      if (dv_lat != 0 && dv_cnt + 1 == dv_lat) begin
        div_ready  <= 1'b1;
        div_result <= ref_div(div_signed, div_a, div_b);
      end
    end
  end

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          stall;
    int          starts;
    int          annuls;
    logic        terr;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] m_hi = 0;
  logic [31:0] m_lo = 0;
  logic        m_terr = 0;

  // Monitor: an instruction is presented when op_valid is seen while idle;
  // it is complete at the first later cycle in which the controller is idle.
  bit trk = 0;
  int n_st, n_s, n_a;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      trk = 0;
    end else if (trk) begin
      if (ex_stall)  n_st++;
      if (div_start) n_s++;
      if (div_annul) n_a++;
      if (!busy) begin
        trk = 0;
        if (exp_q.size() == 0) begin
          chk("scoreboard_underflow", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("hi", {32'd0, hi}, {32'd0, e.hi});
          chk("lo", {32'd0, lo}, {32'd0, e.lo});
          chk("stall_cycles", 64'(n_st), 64'(e.stall));
          chk("start_cycles", 64'(n_s), 64'(e.starts));
          chk("annul_cycles", 64'(n_a), 64'(e.annuls));
          chk("timeout_err", {63'd0, timeout_err}, {63'd0, e.terr});
        end
      end
    end else if (op_valid && !busy) begin
      trk  = 1;
      n_st = ex_stall  ? 1 : 0;
      n_s  = div_start ? 1 : 0;
      n_a  = div_annul ? 1 : 0;
    end
  end

  // Issue one instruction. lat: divider latency (0 = never ready).
  // fk: flush in the fk-th ISSUE/WAIT cycle (0 = ISSUE, -1 = none).
  // fa: flush asserted together with the instruction in IDLE.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int lat, input int fk, input bit fa);
    exp_t        e;
    logic [63:0] res;
    bit          issuing;
    bit          done;
    issuing  = !fa && (o == OP_DIV || o == OP_DIVU) && b != 0;
    e.stall  = 0;
    e.starts = 0;
    e.annuls = 0;
    if (issuing) begin
      if (fk >= 0) begin
        e.starts = fk;
        e.annuls = 1;
        e.stall  = fk + 2;
      end else if (lat == 0) begin
        e.starts = TO;
        e.annuls = 1;
        e.stall  = TO + 2;
        m_terr   = 1'b1;
      end else begin
        res      = ref_div(o == OP_DIV, a, b);
        m_hi     = res[63:32];
        m_lo     = res[31:0];
        e.starts = lat + 1;
        e.stall  = lat + 2;
      end
    end else if (!fa && o == OP_MTHI) begin
      m_hi = a;
    end else if (!fa && o == OP_MTLO) begin
      m_lo = a;
    end
    e.hi   = m_hi;
    e.lo   = m_lo;
    e.terr = m_terr;
    exp_q.push_back(e);

    dv_lat = lat;
    @(posedge clk); #1;
    op_valid = 1'b1; op = o; op_a = a; op_b = b; ex_flush = fa;
    @(posedge clk); #1;
    op_valid = 1'b0; ex_flush = 1'b0;
    if (issuing && fk >= 0) begin
      if (fk > 0) begin
        repeat (fk) @(posedge clk);
        #1;
      end
      ex_flush = 1'b1;
      @(posedge clk); #1;
      ex_flush = 1'b0;
    end
    done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (!busy) done = 1;
    end
    if (!done) chk("busy_release_timeout", 64'd0, 64'd1);
  endtask

  task automatic run_random(input int n);
    logic [2:0]  o;
    logic [31:0] a, b;
    int          sel, lat, fk;
    bit          fa;
    for (int k = 0; k < n; k++) begin
      sel = $urandom_range(0, 9);
      o   = (sel < 4) ? OP_DIV : (sel < 7) ? OP_DIVU : (sel == 7) ? OP_MTHI :
            (sel == 8) ? OP_MTLO : OP_NONE;
      a   = $urandom;
      sel = $urandom_range(0, 9);
      b   = (sel == 0) ? 32'd0 : (sel < 6) ? 32'($urandom_range(1, 20)) :
            (sel < 8) ? -32'($urandom_range(1, 20)) : $urandom;
      lat = $urandom_range(1, TO);
      fk  = ($urandom_range(0, 4) == 0) ? $urandom_range(0, lat) : -1;
      fa  = ($urandom_range(0, 9) == 0);
      run_op(o, a, b, lat, fk, fa);
    end
  endtask

  initial begin
    rst = 1'b1; op_valid = 1'b0; op = OP_NONE; op_a = '0; op_b = '0; ex_flush = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_hi", {32'd0, hi}, 64'd0);
    chk("rst_lo", {32'd0, lo}, 64'd0);
    chk("rst_div_ab", {div_a, div_b}, 64'd0);
    chk("rst_ctrl", {58'd0, div_signed, div_start, div_annul, ex_stall, busy, timeout_err}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Signed -7 / 2 with a 7-cycle divider: stall of 9 cycles
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 7, -1, 1'b0);
    // Divider leaves Ready high between operations from here on
    dv_sticky = 1'b1;
    run_op(OP_DIVU, 32'd100, 32'd7, 5, -1, 1'b0);
    run_op(OP_MTHI, 32'hDEAD_BEEF, 32'd0, 0, -1, 1'b0);
    run_op(OP_DIVU, 32'd9, 32'd4, 3, -1, 1'b0);
    dv_sticky = 1'b0;
    // Zero divisor leaves HI/LO untouched
    run_op(OP_MTHI, 32'h11, 32'd0, 0, -1, 1'b0);
    run_op(OP_MTLO, 32'h22, 32'd0, 0, -1, 1'b0);
    run_op(OP_DIV, 32'd77, 32'd0, 4, -1, 1'b0);
    // Flush in the third WAIT cycle
    run_op(OP_DIV, 32'd50, 32'd5, 7, 3, 1'b0);
    // Flush in ISSUE, flush together with Ready, flush while idle
    run_op(OP_DIVU, 32'd1234, 32'd10, 4, 0, 1'b0);
    run_op(OP_DIVU, 32'd1234, 32'd10, 4, 4, 1'b0);
    run_op(OP_MTLO, 32'h5555, 32'd0, 0, -1, 1'b1);
    // Ready arriving exactly at the watchdog limit still completes
    run_op(OP_DIV, 32'hFFFF_FF00, 32'd7, TO, -1, 1'b0);

    run_random(40);

    // Divider never answers: watchdog fires and the flag sticks
    run_op(OP_DIVU, 32'd1000, 32'd3, 0, -1, 1'b0);
    run_op(OP_DIV, 32'd1000, 32'hFFFF_FFFD, 2, -1, 1'b0);
    chk("terr_sticky", {63'd0, timeout_err}, 64'd1);

    // Reset in the middle of an operation
    dv_lat = 0;
    @(posedge clk); #1;
    op_valid = 1'b1; op = OP_DIVU; op_a = 32'd999; op_b = 32'd9;
    @(posedge clk); #1;
    op_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_start_before_edge", {63'd0, div_start}, 64'd1);
    @(negedge clk);
    chk("midrst_start", {63'd0, div_start}, 64'd0);
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    chk("midrst_terr", {63'd0, timeout_err}, 64'd0);
    chk("midrst_hilo", {hi, lo}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    m_hi = 0; m_lo = 0; m_terr = 0;

    run_random(10);

    @(negedge clk);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_muldiv_issue_ctrl
`default_nettype wire
